// File: rtl/mem_req_arbiter.sv
// ---------------------------------------------------------------------------
// mem_req_arbiter
//   Upstream stage of the address interpreter. Arbitrates the CPU fetch port
//   (read-only) and data port (read/write) onto one ren/wen/addr/ack memory
//   handshake. The granted request is registered, and addr/wdata stay stable
//   for the whole transaction, including the ack-release phase. A watchdog
//   re-issues requests that never ack. After MAX_RETRIES re-issues the request
//   is abandoned and completes with err.
//
// Parameters
//   TIMEOUT_CYCLES  cycles in M_REQ without m_ack before a retry (1..255)
//   MAX_RETRIES     retries before the request is abandoned
//
// Build option
//   MEM_REQ_ARB_RR_EN  defined   : round-robin between fetch and data
//                      undefined : fixed priority, data over fetch
//
// Ports
//   clk, rst            clock; asynchronous active-high reset
//   i_req/i_addr        fetch request (level) and address
//   i_done/i_rdata      fetch completion pulse and read data
//   d_req/d_we/d_addr/d_wdata  data request (level), direction, addr, wdata
//   d_done/d_rdata      data completion pulse and read data (0 for writes)
//   m_ren/m_wen         read / write request to the interpreter
//   m_addr/m_wdata      registered address / write data of the granted request
//   m_ack/m_rdata       interpreter acknowledge and read data
//   err                 pulses with done when a request is abandoned
// ---------------------------------------------------------------------------
`timescale 1ns/1ps

module mem_req_arbiter #(
    parameter int unsigned TIMEOUT_CYCLES = 255,
    parameter int unsigned MAX_RETRIES    = 3
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        i_req,
    input  logic [31:0] i_addr,
    output logic        i_done,
    output logic [31:0] i_rdata,
    input  logic        d_req,
    input  logic        d_we,
    input  logic [31:0] d_addr,
    input  logic [31:0] d_wdata,
    output logic        d_done,
    output logic [31:0] d_rdata,
    output logic        m_ren,
    output logic        m_wen,
    output logic [31:0] m_addr,
    output logic [31:0] m_wdata,
    input  logic        m_ack,
    input  logic [31:0] m_rdata,
    output logic        err
);

    localparam logic [7:0] TMO_LAST  = 8'(TIMEOUT_CYCLES - 1);
    localparam logic [7:0] RETRY_MAX = 8'(MAX_RETRIES);

    typedef enum logic [1:0] {
        IDLE      = 2'd0,
        M_REQ     = 2'd1,
        M_RETRY   = 2'd2,
        M_RELEASE = 2'd3
    } state_t;

    state_t      r_state,   w_state_nxt;
    logic        r_ren,     w_ren_nxt;
    logic        r_wen,     w_wen_nxt;
    logic        r_we,      w_we_nxt;
    logic        r_owner_d, w_owner_d_nxt;
    logic [31:0] r_addr,    w_addr_nxt;
    logic [31:0] r_wdata,   w_wdata_nxt;
    logic [7:0]  r_tcnt,    w_tcnt_nxt;
    logic [7:0]  r_retry,   w_retry_nxt;
    logic        r_i_done,  w_i_done_nxt;
    logic        r_d_done,  w_d_done_nxt;
    logic        r_err,     w_err_nxt;
    logic [31:0] r_rdata,   w_rdata_nxt;

    logic        w_any_req;
    logic        w_grant_d;
    logic        w_timeout;

    assign w_any_req = i_req | d_req;
    assign w_timeout = (r_tcnt == TMO_LAST);

`ifdef MEM_REQ_ARB_RR_EN
    // Set after a data grant so the next collision goes to fetch.
    logic r_rr_prefer_i;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_rr_prefer_i <= 1'b0;
        end else if (r_state == IDLE && w_any_req) begin
            r_rr_prefer_i <= w_grant_d;
        end
    end

    assign w_grant_d = d_req & (~i_req | ~r_rr_prefer_i);
`else
    assign w_grant_d = d_req;
`endif

    // State and datapath registers
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state   <= IDLE;
            r_ren     <= 1'b0;
            r_wen     <= 1'b0;
            r_we      <= 1'b0;
            r_owner_d <= 1'b0;
            r_addr    <= '0;
            r_wdata   <= '0;
            r_tcnt    <= '0;
            r_retry   <= '0;
            r_i_done  <= 1'b0;
            r_d_done  <= 1'b0;
            r_err     <= 1'b0;
            r_rdata   <= '0;
        end else begin
            r_state   <= w_state_nxt;
            r_ren     <= w_ren_nxt;
            r_wen     <= w_wen_nxt;
            r_we      <= w_we_nxt;
            r_owner_d <= w_owner_d_nxt;
            r_addr    <= w_addr_nxt;
            r_wdata   <= w_wdata_nxt;
            r_tcnt    <= w_tcnt_nxt;
            r_retry   <= w_retry_nxt;
            r_i_done  <= w_i_done_nxt;
            r_d_done  <= w_d_done_nxt;
            r_err     <= w_err_nxt;
            r_rdata   <= w_rdata_nxt;
        end
    end

    // Next-state and next-output logic
    always_comb begin
        w_state_nxt   = r_state;
        w_ren_nxt     = r_ren;
        w_wen_nxt     = r_wen;
        w_we_nxt      = r_we;
        w_owner_d_nxt = r_owner_d;
        w_addr_nxt    = r_addr;
        w_wdata_nxt   = r_wdata;
        w_tcnt_nxt    = r_tcnt;
        w_retry_nxt   = r_retry;
        w_i_done_nxt  = 1'b0;
        w_d_done_nxt  = 1'b0;
        w_err_nxt     = 1'b0;
        w_rdata_nxt   = r_rdata;

        case (r_state)
            IDLE: begin
                if (w_any_req) begin
                    w_owner_d_nxt = w_grant_d;
                    if (w_grant_d) begin
                        w_we_nxt    = d_we;
                        w_addr_nxt  = d_addr;
                        w_wdata_nxt = d_wdata;
                        w_ren_nxt   = ~d_we;
                        w_wen_nxt   = d_we;
                    end else begin
                        w_we_nxt    = 1'b0;
                        w_addr_nxt  = i_addr;
                        w_wdata_nxt = '0;
                        w_ren_nxt   = 1'b1;
                        w_wen_nxt   = 1'b0;
                    end
                    w_tcnt_nxt  = '0;
                    w_retry_nxt = '0;
                    w_state_nxt = M_REQ;
                end
            end

            M_REQ: begin
                // An ack arriving on the timeout cycle still completes normally.
                if (m_ack) begin
                    w_ren_nxt    = 1'b0;
                    w_wen_nxt    = 1'b0;
                    w_rdata_nxt  = r_we ? '0 : m_rdata;
                    w_i_done_nxt = ~r_owner_d;
                    w_d_done_nxt = r_owner_d;
                    w_state_nxt  = M_RELEASE;
                end else if (w_timeout) begin
                    w_ren_nxt = 1'b0;
                    w_wen_nxt = 1'b0;
                    if (r_retry == RETRY_MAX) begin
                        w_rdata_nxt  = '0;
                        w_i_done_nxt = ~r_owner_d;
                        w_d_done_nxt = r_owner_d;
                        w_err_nxt    = 1'b1;
                        w_state_nxt  = M_RELEASE;
                    end else begin
                        w_retry_nxt = r_retry + 8'd1;
                        w_state_nxt = M_RETRY;
                    end
                end else begin
                    w_tcnt_nxt = r_tcnt + 8'd1;
                end
            end

            M_RETRY: begin
                // One idle cycle on the bus, then the same request again.
                w_ren_nxt   = ~r_we;
                w_wen_nxt   = r_we;
                w_tcnt_nxt  = '0;
                w_state_nxt = M_REQ;
            end

            M_RELEASE: begin
                if (!m_ack) begin
                    w_state_nxt = IDLE;
                end
            end

            default: w_state_nxt = IDLE;
        endcase
    end

    assign m_ren   = r_ren;
    assign m_wen   = r_wen;
    assign m_addr  = r_addr;
    assign m_wdata = r_wdata;
    assign i_done  = r_i_done;
    assign d_done  = r_d_done;
    assign err     = r_err;
    assign i_rdata = {32{r_i_done}} & r_rdata;
    assign d_rdata = {32{r_d_done}} & r_rdata;

endmodule

// File: tb/tb_mem_req_arbiter.sv
// ---------------------------------------------------------------------------
// tb_mem_req_arbiter
//   Directed bench for mem_req_arbiter with TIMEOUT_CYCLES=8, MAX_RETRIES=2.
//   Single transactions come from a vector table; collision, timeout, retry
//   recovery and asynchronous reset are hand-written sequences. Inputs are
//   driven and outputs sampled 1 ns after the rising edge.
// ---------------------------------------------------------------------------
`timescale 1ns/1ps

module tb_mem_req_arbiter;

    localparam int unsigned TO = 8;
    localparam int unsigned MR = 2;

    logic        clk;
    logic        rst;
    logic        i_req;
    logic [31:0] i_addr;
    logic        i_done;
    logic [31:0] i_rdata;
    logic        d_req;
    logic        d_we;
    logic [31:0] d_addr;
    logic [31:0] d_wdata;
    logic        d_done;
    logic [31:0] d_rdata;
    logic        m_ren;
    logic        m_wen;
    logic [31:0] m_addr;
    logic [31:0] m_wdata;
    logic        m_ack;
    logic [31:0] m_rdata;
    logic        err;

    int unsigned n_cmp = 0;
    int unsigned n_bad = 0;

    mem_req_arbiter #(
        .TIMEOUT_CYCLES(TO),
        .MAX_RETRIES   (MR)
    ) dut (
        .clk    (clk),
        .rst    (rst),
        .i_req  (i_req),
        .i_addr (i_addr),
        .i_done (i_done),
        .i_rdata(i_rdata),
        .d_req  (d_req),
        .d_we   (d_we),
        .d_addr (d_addr),
        .d_wdata(d_wdata),
        .d_done (d_done),
        .d_rdata(d_rdata),
        .m_ren  (m_ren),
        .m_wen  (m_wen),
        .m_addr (m_addr),
        .m_wdata(m_wdata),
        .m_ack  (m_ack),
        .m_rdata(m_rdata),
        .err    (err)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic        is_d;
        logic        we;
        logic [31:0] addr;
        logic [31:0] wdata;
        int unsigned dly;
        logic [31:0] ack_rdata;
        logic [31:0] exp_rdata;
    } vec_t;

    vec_t vecs [6];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %h expected %h (t=%0t)", name, act, exp, $time);
        end
    endtask

    // Grant edge, dly cycles of held request, ack, then the done cycle.
    task automatic serve(input logic exp_d, input logic exp_we, input logic [31:0] exp_addr,
                         input logic [31:0] exp_wdata, input int unsigned dly,
                         input logic [31:0] ack_rdata, input logic [31:0] exp_rdata);
        @(posedge clk); #1;
        chk("grant_ren", m_ren, !exp_we);
        chk("grant_wen", m_wen, exp_we);
        chk("grant_addr", m_addr, exp_addr);
        if (exp_we) chk("grant_wdata", m_wdata, exp_wdata);
        for (int unsigned k = 0; k < dly; k++) begin
            @(posedge clk); #1;
            chk("hold_renwen", {m_ren, m_wen}, {!exp_we, exp_we});
            chk("hold_addr", m_addr, exp_addr);
            chk("hold_nodone", {i_done, d_done, err}, 0);
        end
        m_ack   = 1'b1;
        m_rdata = ack_rdata;
        @(posedge clk); #1;
        chk("done_renwen_low", {m_ren, m_wen, m_ack}, 3'b001);
        chk("i_done", i_done, !exp_d);
        chk("d_done", d_done, exp_d);
        chk("done_err", err, 0);
        chk("done_rdata", exp_d ? d_rdata : i_rdata, exp_rdata);
        chk("done_addr_held", m_addr, exp_addr);
        if (exp_we) chk("done_wdata_held", m_wdata, exp_wdata);
    endtask

    task automatic release_ack();
        m_ack   = 1'b0;
        m_rdata = '0;
        @(posedge clk); #1;
        chk("post_done_low", {i_done, d_done, err}, 0);
        chk("release_renwen", {m_ren, m_wen}, 0);
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "time limit");
    end

    initial begin
        vecs[0] = '{1'b0, 1'b0, 32'hBFC0_0000, 32'h0000_0000, 3, 32'h3C08_1F80, 32'h3C08_1F80};
        vecs[1] = '{1'b1, 1'b1, 32'h8000_0010, 32'hDEAD_BEEF, 2, 32'h1234_5678, 32'h0000_0000};
        vecs[2] = '{1'b1, 1'b0, 32'h8000_0020, 32'h0000_0000, 0, 32'hA5A5_5A5A, 32'hA5A5_5A5A};
        vecs[3] = '{1'b0, 1'b0, 32'hBFC0_0004, 32'h0000_0000, TO - 1, 32'h0000_0001, 32'h0000_0001};
        vecs[4] = '{1'b1, 1'b1, 32'hFFFF_FFFC, 32'h0000_0000, 1, 32'hFFFF_FFFF, 32'h0000_0000};
        vecs[5] = '{1'b0, 1'b0, 32'h0000_0000, 32'h0000_0000, 0, 32'hFFFF_FFFF, 32'hFFFF_FFFF};

        rst = 1'b1; i_req = 1'b0; i_addr = '0; d_req = 1'b0; d_we = 1'b0;
        d_addr = '0; d_wdata = '0; m_ack = 1'b0; m_rdata = '0;
        repeat (2) @(posedge clk);
        #1;
        chk("rst_ctrl", {m_ren, m_wen, i_done, d_done, err}, 0);
        chk("rst_addr", m_addr, 0);
        chk("rst_wdata", m_wdata, 0);
        chk("rst_rdata", i_rdata | d_rdata, 0);
        rst = 1'b0;

        // Stale ack in IDLE is ignored
        m_ack = 1'b1;
        @(posedge clk); #1;
        chk("idle_ack_ignored", {m_ren, m_wen, i_done, d_done, err}, 0);
        m_ack = 1'b0;
        @(posedge clk); #1;

        // Single transactions from the table
        for (int unsigned n = 0; n < 6; n++) begin
            vec_t v;
            v = vecs[n];
            if (v.is_d) begin
                d_req = 1'b1; d_we = v.we; d_addr = v.addr; d_wdata = v.wdata;
            end else begin
                i_req = 1'b1; i_addr = v.addr;
            end
            serve(v.is_d, v.we, v.addr, v.wdata, v.dly, v.ack_rdata, v.exp_rdata);
            i_req = 1'b0;
            d_req = 1'b0;
            release_ack();
        end

        // Collision; data keeps requesting after its first done
        i_req = 1'b1; i_addr = 32'hBFC0_0100;
        d_req = 1'b1; d_we = 1'b0; d_addr = 32'h8000_0100;
        serve(1'b1, 1'b0, 32'h8000_0100, 32'h0, 1, 32'h1111_1111, 32'h1111_1111);
        d_addr = 32'h8000_0200;
        release_ack();
`ifdef MEM_REQ_ARB_RR_EN
        serve(1'b0, 1'b0, 32'hBFC0_0100, 32'h0, 0, 32'h2222_2222, 32'h2222_2222);
        i_req = 1'b0;
        release_ack();
        serve(1'b1, 1'b0, 32'h8000_0200, 32'h0, 0, 32'h3333_3333, 32'h3333_3333);
        d_req = 1'b0;
        release_ack();
`else
        serve(1'b1, 1'b0, 32'h8000_0200, 32'h0, 0, 32'h2222_2222, 32'h2222_2222);
        d_req = 1'b0;
        release_ack();
        serve(1'b0, 1'b0, 32'hBFC0_0100, 32'h0, 0, 32'h3333_3333, 32'h3333_3333);
        i_req = 1'b0;
        release_ack();
`endif

        // Timeout: never acked; gaps after each TO cycles, abandon on the third
        i_req = 1'b1; i_addr = 32'h0000_1000;
        @(posedge clk); #1;
        chk("to_grant_ren", m_ren, 1);
        for (int unsigned e = 1; e <= (MR + 1) * (TO + 1) - 1; e++) begin
            logic gap;
            logic fin;
            @(posedge clk); #1;
            gap = ((e % (TO + 1)) == TO);
            fin = (e == (MR + 1) * (TO + 1) - 1);
            chk("to_ren", m_ren, !gap);
            chk("to_addr", m_addr, 32'h0000_1000);
            chk("to_done", i_done, fin);
            chk("to_err", err, fin);
            if (fin) chk("to_rdata", i_rdata, 0);
        end
        i_req = 1'b0;
        release_ack();

        // Retry recovery; stale ack during M_RETRY must be ignored
        d_req = 1'b1; d_we = 1'b0; d_addr = 32'h8000_0040;
        @(posedge clk); #1;
        chk("rr_grant_ren", m_ren, 1);
        for (int unsigned e = 1; e <= TO; e++) begin
            @(posedge clk); #1;
            chk("rr_ren", m_ren, e != TO);
        end
        m_ack = 1'b1;
        @(posedge clk); #1;
        chk("rr_reissue_ren", m_ren, 1);
        chk("rr_stale_ack_nodone", {d_done, i_done, err}, 0);
        m_ack = 1'b0;
        @(posedge clk); #1;
        chk("rr_held_ren", m_ren, 1);
        m_ack = 1'b1; m_rdata = 32'hCAFE_F00D;
        @(posedge clk); #1;
        chk("rr_done", {d_done, i_done}, 2'b10);
        chk("rr_err", err, 0);
        chk("rr_rdata", d_rdata, 32'hCAFE_F00D);
        chk("rr_ren_low", m_ren, 0);
        d_req = 1'b0;
        release_ack();

        // Asynchronous reset while in M_REQ
        i_req = 1'b1; i_addr = 32'hBFC0_0200;
        @(posedge clk); #1;
        chk("ar_grant_ren", m_ren, 1);
        @(posedge clk); #1;
        rst = 1'b1;
        #1;
        chk("ar_ren_async_low", m_ren, 0);
        @(posedge clk); #1;
        chk("ar_no_done", {i_done, d_done, err, m_ren, m_wen}, 0);
        rst = 1'b0;
        serve(1'b0, 1'b0, 32'hBFC0_0200, 32'h0, 2, 32'h0BAD_CAFE, 32'h0BAD_CAFE);
        i_req = 1'b0;
        release_ack();

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
